// File: rtl/pmod_ad2_i2c.sv
// rtl/pmod_ad2_i2c.sv - AD7991 (PmodAD2) single-conversion I2C master with open-drain SCL/SDA enables
module pmod_ad2_i2c #(
    parameter int         CLK_HZ   = 65_000_000,
    parameter int         I2C_HZ   = 100_000,
    parameter logic [6:0] DEV_ADDR = 7'h28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [3:0]  adress,
    input  logic        sda_i,
    output logic        scl_oe,
    output logic        sda_oe,
    output logic [11:0] data,
    output logic [1:0]  chan_id,
    output logic        data_valid,
    output logic        busy,
    output logic        ack_error
);
    localparam int QTR_DIV = CLK_HZ / (4 * I2C_HZ);
    localparam int QTR     = (QTR_DIV < 1) ? 1 : QTR_DIV;
    localparam int QW      = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QTR - 1);

    typedef enum logic [3:0] {
        IDLE, START, WR_ADDR, WR_ACK, WR_CFG, CFG_ACK, RSTART, RD_ADDR,
        RD_ACK, RD_MSB, M_ACK, RD_LSB, M_NACK, STOP, DONE
    } state_t;

    state_t          r_state, w_n_state;
    logic [QW-1:0]   r_qcnt, w_n_qcnt;
    logic [1:0]      r_quarter, w_n_quarter;
    logic [2:0]      r_bit, w_n_bit;
    logic [7:0]      r_shift, w_n_shift;
    logic [5:0]      r_msb;
    logic [3:0]      r_adr;
    logic            r_nack;
    logic            w_qend, w_cell_end, w_sample, w_nack;

    function automatic logic fn_scl_low(input state_t s, input logic [1:0] q);
        case (s)
            IDLE, DONE:     return 1'b0;
            START, RSTART:  return q == 2'd3;
            STOP:           return q == 2'd0;
            default:        return !q[1];
        endcase
    endfunction

    function automatic logic fn_sda_low(input state_t s, input logic [1:0] q, input logic tx);
        case (s)
            START, RSTART:             return q[1];
            STOP:                      return !q[1];
            WR_ADDR, WR_CFG, RD_ADDR:  return !tx;
            M_ACK:                     return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    always_comb begin
        w_qend      = (r_qcnt == QLAST);
        w_cell_end  = w_qend && (r_quarter == 2'd3);
        w_sample    = (r_quarter == 2'd3) && (r_qcnt == '0);
        // With QTR=1 the sample clock is also the cell's last clock, so use the live pin
        w_nack      = w_sample ? sda_i : r_nack;
        w_n_state   = r_state;
        w_n_qcnt    = r_qcnt;
        w_n_quarter = r_quarter;
        w_n_bit     = r_bit;
        w_n_shift   = r_shift;

        if (r_state == IDLE || r_state == DONE) begin
            w_n_qcnt    = '0;
            w_n_quarter = 2'd0;
        end else if (w_qend) begin
            w_n_qcnt    = '0;
            w_n_quarter = r_quarter + 2'd1;
        end else begin
            w_n_qcnt    = r_qcnt + 1'b1;
        end

        if (w_sample && (r_state == RD_MSB || r_state == RD_LSB))
            w_n_shift = {r_shift[6:0], sda_i};

        case (r_state)
            IDLE: if (tick) w_n_state = START;
            DONE: w_n_state = IDLE;
            default: if (w_cell_end) begin
                case (r_state)
                    START: begin
                        w_n_state = WR_ADDR;
                        w_n_bit   = 3'd7;
                        w_n_shift = {DEV_ADDR, 1'b0};
                    end
                    WR_ADDR, WR_CFG, RD_ADDR: begin
                        if (r_bit == 3'd0)
                            w_n_state = (r_state == WR_ADDR) ? WR_ACK :
                                        (r_state == WR_CFG)  ? CFG_ACK : RD_ACK;
                        else begin
                            w_n_bit   = r_bit - 3'd1;
                            w_n_shift = {r_shift[6:0], 1'b0};
                        end
                    end
                    WR_ACK: begin
                        w_n_state = w_nack ? STOP : WR_CFG;
                        w_n_bit   = 3'd7;
                        w_n_shift = {r_adr, 4'b0000};
                    end
                    CFG_ACK: w_n_state = w_nack ? STOP : RSTART;
                    RSTART: begin
                        w_n_state = RD_ADDR;
                        w_n_bit   = 3'd7;
                        w_n_shift = {DEV_ADDR, 1'b1};
                    end
                    RD_ACK: begin
                        w_n_state = w_nack ? STOP : RD_MSB;
                        w_n_bit   = 3'd7;
                    end
                    RD_MSB, RD_LSB: begin
                        if (r_bit == 3'd0)
                            w_n_state = (r_state == RD_MSB) ? M_ACK : M_NACK;
                        else
                            w_n_bit = r_bit - 3'd1;
                    end
                    M_ACK: begin
                        w_n_state = RD_LSB;
                        w_n_bit   = 3'd7;
                    end
                    M_NACK: w_n_state = STOP;
                    STOP:   w_n_state = DONE;
                    default: w_n_state = IDLE;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_qcnt     <= '0;
            r_quarter  <= 2'd0;
            r_bit      <= 3'd0;
            r_shift    <= 8'h00;
            r_msb      <= 6'd0;
            r_adr      <= 4'd0;
            r_nack     <= 1'b0;
            scl_oe     <= 1'b0;
            sda_oe     <= 1'b0;
            data       <= 12'd0;
            chan_id    <= 2'd0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            ack_error  <= 1'b0;
        end else begin
            r_state    <= w_n_state;
            r_qcnt     <= w_n_qcnt;
            r_quarter  <= w_n_quarter;
            r_bit      <= w_n_bit;
            r_shift    <= w_n_shift;
            // Pins are decoded from the next position so SDA moves on the first clock of Q0
            scl_oe     <= fn_scl_low(w_n_state, w_n_quarter);
            sda_oe     <= fn_sda_low(w_n_state, w_n_quarter, w_n_shift[7]);
            data_valid <= 1'b0;
            if (w_sample)
                r_nack <= sda_i;
            if (r_state == IDLE && tick) begin
                r_adr     <= adress;
                ack_error <= 1'b0;
                busy      <= 1'b1;
            end
            if (w_cell_end && w_nack &&
                (r_state == WR_ACK || r_state == CFG_ACK || r_state == RD_ACK))
                ack_error <= 1'b1;
            if (w_cell_end && r_state == M_ACK)
                r_msb <= r_shift[5:0];
            if (w_cell_end && r_state == STOP) begin
                busy <= 1'b0;
                if (!ack_error) begin
                    data       <= {r_msb[3:0], r_shift};
                    chan_id    <= r_msb[5:4];
                    data_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pmod_ad2_i2c.sv
// tb/tb_pmod_ad2_i2c.sv - self-checking bench for pmod_ad2_i2c with an AD7991 slave model
module tb_pmod_ad2_i2c;
    localparam int LAT = 1921;

    logic        clk, rst, tick, sda_i;
    logic [3:0]  adress;
    logic        scl_oe, sda_oe, data_valid, busy, ack_error;
    logic [11:0] data;
    logic [1:0]  chan_id;

    int total, bad, cyc;
    int starts, stops, dv_count, dv_cyc, t_tick, nbit, rise_n, r1, r2;
    logic slave_low, rw, nack_w, m_ack_line, m_nack_line, prev_scl, prev_sda;
    logic [7:0] sh, rd0, rd1;
    logic [7:0] wbytes[$];

    pmod_ad2_i2c #(.CLK_HZ(4_000_000), .I2C_HZ(100_000), .DEV_ADDR(7'h28)) dut (
        .clk(clk), .rst(rst), .tick(tick), .adress(adress), .sda_i(sda_i),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .data(data), .chan_id(chan_id),
        .data_valid(data_valid), .busy(busy), .ack_error(ack_error)
    );

    assign sda_i = !(sda_oe || slave_low);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Bus monitor and AD7991 slave, working only from line events
    initial begin
        logic line;
        int   k;
        prev_scl = 1'b0; prev_sda = 1'b0; slave_low = 1'b0; nbit = 0; rw = 1'b0; sh = 8'h00;
        forever begin
            @(negedge clk);
            line = !(sda_oe || slave_low);
            if (!prev_scl && !scl_oe && !prev_sda && sda_oe) begin
                starts++; nbit = 0; slave_low = 1'b0;
            end else if (!prev_scl && !scl_oe && prev_sda && !sda_oe) begin
                stops++;
            end else if (prev_scl && !scl_oe) begin
                nbit++; rise_n++;
                if (rise_n == 1) r1 = cyc;
                if (rise_n == 2) r2 = cyc;
                if (nbit <= 8) begin
                    sh = {sh[6:0], line};
                    if (nbit == 8) begin wbytes.push_back(sh); rw = sh[0]; end
                end else if (!rw && nbit >= 10 && nbit <= 17) begin
                    sh = {sh[6:0], line};
                    if (nbit == 17) wbytes.push_back(sh);
                end else if (rw && nbit == 18) m_ack_line = line;
                else if (rw && nbit == 27) m_nack_line = line;
            end else if (!prev_scl && scl_oe) begin
                k = nbit + 1;
                slave_low = 1'b0;
                if (k == 9) slave_low = (sh[7:1] == 7'h28) && !(nack_w && sh == 8'h50);
                else if (!rw && k == 18) slave_low = 1'b1;
                else if (rw && k >= 10 && k <= 17) slave_low = !rd0[17-k];
                else if (rw && k >= 19 && k <= 26) slave_low = !rd1[26-k];
            end
            if (data_valid === 1'b1) begin dv_count++; dv_cyc = cyc; end
            prev_scl = scl_oe; prev_sda = sda_oe;
        end
    end

    task automatic clear_mon();
        starts = 0; stops = 0; dv_count = 0; dv_cyc = -1; rise_n = 0; r1 = 0; r2 = 0;
        m_ack_line = 1'bx; m_nack_line = 1'bx;
        wbytes.delete();
    endtask

    task automatic run_txn(input logic [3:0] adr, input logic [7:0] b0, input logic [7:0] b1,
                           input logic nack, input int dly);
        clear_mon();
        rd0 = b0; rd1 = b1; nack_w = nack;
        @(negedge clk);
        adress = adr; tick = 1'b1; t_tick = cyc;
        for (int i = 1; i <= LAT + 60; i++) begin
            @(negedge clk);
            tick = (dly != 0 && i == dly);
            adress = 4'($urandom);
        end
        tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b0; adress = 4'd0; nack_w = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({scl_oe, sda_oe} !== 2'b00) begin bad++; $display("FAIL reset_lines got=%b exp=00", {scl_oe, sda_oe}); end
        total++; if ({busy, data_valid, ack_error} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy, data_valid, ack_error}); end
        total++; if ({chan_id, data} !== 14'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", {chan_id, data}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_case1();
        run_txn(4'b0001, 8'h0A, 8'hBC, 1'b0, 0);
        total++; if (wbytes.size() != 3) begin bad++; $display("FAIL c1_nbytes got=%0d exp=3", wbytes.size()); end
        if (wbytes.size() == 3) begin
            total++; if ({wbytes[0], wbytes[1], wbytes[2]} !== 24'h501051) begin bad++; $display("FAIL c1_bytes got=%h exp=501051", {wbytes[0], wbytes[1], wbytes[2]}); end
        end
        total++; if ({m_ack_line, m_nack_line} !== 2'b01) begin bad++; $display("FAIL c1_master_ack got=%b exp=01", {m_ack_line, m_nack_line}); end
        total++; if ({chan_id, data} !== {2'd0, 12'hABC}) begin bad++; $display("FAIL c1_data got=%h exp=%h", {chan_id, data}, {2'd0, 12'hABC}); end
        total++; if (ack_error !== 1'b0) begin bad++; $display("FAIL c1_ack_error got=%b exp=0", ack_error); end
        total++; if (dv_count != 1) begin bad++; $display("FAIL c1_dv_count got=%0d exp=1", dv_count); end
        total++; if (dv_cyc - t_tick != LAT) begin bad++; $display("FAIL c1_latency got=%0d exp=%0d", dv_cyc - t_tick, LAT); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL c1_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_case2();
        run_txn(4'b1000, 8'h3F, 8'hFF, 1'b0, 0);
        total++; if (wbytes.size() < 2 || wbytes[1] !== 8'h80) begin bad++; $display("FAIL c2_cfg got=%h exp=80", (wbytes.size() > 1) ? wbytes[1] : 8'hxx); end
        total++; if ({chan_id, data} !== {2'd3, 12'hFFF}) begin bad++; $display("FAIL c2_data got=%h exp=%h", {chan_id, data}, {2'd3, 12'hFFF}); end
        total++; if (r2 - r1 != 40) begin bad++; $display("FAIL c2_scl_period got=%0d exp=40", r2 - r1); end
        total++; if (starts != 2 || stops != 1) begin bad++; $display("FAIL c2_sda_while_scl_high got=%0d/%0d exp=2/1", starts, stops); end
    endtask

    task automatic test_nack();
        run_txn(4'b0001, 8'h0A, 8'hBC, 1'b0, 0);
        run_txn(4'b0010, 8'h15, 8'h55, 1'b1, 0);
        total++; if (ack_error !== 1'b1) begin bad++; $display("FAIL nack_flag got=%b exp=1", ack_error); end
        total++; if (stops != 1) begin bad++; $display("FAIL nack_stop got=%0d exp=1", stops); end
        total++; if (dv_count != 0) begin bad++; $display("FAIL nack_dv got=%0d exp=0", dv_count); end
        total++; if ({chan_id, data} !== {2'd0, 12'hABC}) begin bad++; $display("FAIL nack_hold got=%h exp=%h", {chan_id, data}, {2'd0, 12'hABC}); end
        total++; if (wbytes.size() != 1) begin bad++; $display("FAIL nack_bytes got=%0d exp=1", wbytes.size()); end
        run_txn(4'b0100, 8'h21, 8'h34, 1'b0, 0);
        total++; if (ack_error !== 1'b0) begin bad++; $display("FAIL nack_clear got=%b exp=0", ack_error); end
        total++; if ({chan_id, data} !== {2'd2, 12'h134}) begin bad++; $display("FAIL nack_next_data got=%h exp=%h", {chan_id, data}, {2'd2, 12'h134}); end
    endtask

    task automatic test_back_to_back();
        run_txn(4'b0010, 8'hC7, 8'h5A, 1'b0, 100);
        total++; if (starts != 2 || stops != 1) begin bad++; $display("FAIL b2b_frames got=%0d/%0d exp=2/1", starts, stops); end
        total++; if (dv_count != 1) begin bad++; $display("FAIL b2b_dv got=%0d exp=1", dv_count); end
        total++; if (wbytes.size() < 2 || wbytes[1] !== 8'h20) begin bad++; $display("FAIL b2b_cfg got=%h exp=20", (wbytes.size() > 1) ? wbytes[1] : 8'hxx); end
        total++; if ({chan_id, data} !== {2'd0, 12'h75A}) begin bad++; $display("FAIL b2b_data got=%h exp=%h", {chan_id, data}, {2'd0, 12'h75A}); end
    endtask

    task automatic test_reset_mid();
        bit hit;
        clear_mon();
        rd0 = 8'h12; rd1 = 8'h34; nack_w = 1'b0; hit = 0;
        @(negedge clk);
        adress = 4'b0001; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk);
            if (starts == 2 && rw && nbit == 12) hit = 1;
        end
        total++; if (!hit) begin bad++; $display("FAIL mid_reach_rd_msb got=timeout exp=reached"); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if ({scl_oe, sda_oe, busy} !== 3'b000) begin bad++; $display("FAIL mid_reset_out got=%b exp=000", {scl_oe, sda_oe, busy}); end
        total++; if (data !== 12'd0) begin bad++; $display("FAIL mid_reset_data got=%h exp=000", data); end
        repeat (5) @(negedge clk);
        run_txn(4'b0100, 8'h2E, 8'h9D, 1'b0, 0);
        total++; if (dv_count != 1 || {chan_id, data} !== {2'd2, 12'hE9D}) begin bad++; $display("FAIL mid_next got=%0d/%h exp=1/%h", dv_count, {chan_id, data}, {2'd2, 12'hE9D}); end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [7:0] b0, b1;
        for (int n = 0; n < 4; n++) begin
            a  = 4'b0001 << $urandom_range(3, 0);
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            run_txn(a, b0, b1, 1'b0, 0);
            total++; if ({chan_id, data} !== {b0[5:4], b0[3:0], b1}) begin bad++; $display("FAIL rnd_data got=%h exp=%h", {chan_id, data}, {b0[5:4], b0[3:0], b1}); end
            total++; if (wbytes.size() < 2 || wbytes[1] !== {a, 4'b0000}) begin bad++; $display("FAIL rnd_cfg got=%h exp=%h", (wbytes.size() > 1) ? wbytes[1] : 8'hxx, {a, 4'b0000}); end
            total++; if (dv_count != 1 || dv_cyc - t_tick != LAT) begin bad++; $display("FAIL rnd_dv got=%0d@%0d exp=1@%0d", dv_count, dv_cyc - t_tick, LAT); end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        clear_mon();
        test_reset();
        test_case1();
        test_case2();
        test_nack();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pmod_ad2_i2c.md
Name: pmod_ad2_i2c

Overview:
- I2C master that performs a single AD7991 (PmodAD2) conversion per request.
- On a one-cycle tick from the channel-sequencing FSM, it writes the channel-select config byte, reads back the 2-byte result and presents the 12-bit sample on data.
- The sequencer's 12-bit in port is fed from data.
- Drives the PmodAD2 SCL/SDA pins through open-drain enables.

Parameters:
- CLK_HZ, 65_000_000, system clock frequency.
- I2C_HZ, 100_000, SCL frequency.
- DEV_ADDR, 7'h28, AD7991 7-bit slave address.
- Derived: QTR = CLK_HZ/(4*I2C_HZ), integer division, minimum 1. Default is 162.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-high; clock clk.
- tick  in  1  start request, one-cycle pulse.
- adress  in  4  one-hot channel select, CH3..CH0.
- sda_i  in  1  SDA pin value.
- scl_oe  out  1  1 pulls SCL low; 0 releases (pulled high).
- sda_oe  out  1  1 pulls SDA low; 0 releases.
- data  out  12  last good conversion result.
- chan_id  out  2  channel ID bits from the last good result.
- data_valid  out  1  one-cycle pulse when data/chan_id update.
- busy  out  1  transaction in progress.
- ack_error  out  1  last transaction saw a slave NACK; sticky until next tick.

Behaviour:
- Reset values:
  - data=0, chan_id=0, data_valid=0, busy=0, ack_error=0.
  - scl_oe=0, sda_oe=0: both lines released on the first clock edge with rst=1.
  - State goes to IDLE and all counters clear.
- Reset mid-transaction: abort immediately with no STOP. The next transaction begins with START.
- Tick acceptance:
  - tick is sampled only in IDLE.
  - adress is captured with tick and held internally for the whole transaction.
  - A tick while busy=1 is ignored, not queued.
  - busy=1 from the cycle after an accepted tick until the cycle data_valid (or the error end) asserts; busy=0 in that final cycle.
- Bit cell timing: 4 quarters of QTR clocks each.
  - Q0: SCL low; SDA updated at the start of Q0.
  - Q1: SCL low.
  - Q2: SCL released.
  - Q3: SCL released; sda_i sampled on the first clock of Q3.
  - SDA never changes while SCL is released, except in START/Sr/STOP.
- START / Sr cell: SDA released and SCL released for Q0–Q1, SDA low at Q2, SCL low at the end of Q3.
- STOP cell: SDA low with SCL low in Q0, SCL released at Q1, SDA released at Q2; both remain released in Q3 and afterwards.
- Sequence, MSB first, each byte followed by an ack bit:
  - START.
  - {DEV_ADDR,0} = 0x50, then slave ACK.
  - Config byte {adress,4'b0000}, then slave ACK. REF_SEL/FLTR/delay bits are all 0.
  - Sr.
  - {DEV_ADDR,1} = 0x51, then slave ACK.
  - Read MSB, then master ACK (sda_oe=1).
  - Read LSB, then master NACK (sda_oe=0).
  - STOP.
- States: IDLE, START, WR_ADDR, WR_ACK, WR_CFG, CFG_ACK, RSTART, RD_ADDR, RD_ACK, RD_MSB, M_ACK, RD_LSB, M_NACK, STOP, DONE.
- Slave ACK means sda_i=0 at sample time. sda_oe=0 throughout slave-ack and read bits.
- NACK handling, at any of the three slave-ack points:
  - Set ack_error=1 and jump to STOP.
  - No data_valid pulse; data and chan_id hold their previous values.
- Result on success (DONE, one cycle after STOP completes):
  - data = {MSB[3:0], LSB[7:0]}.
  - chan_id = MSB[5:4]; MSB[7:6] are ignored.
  - data_valid=1 for exactly one cycle.
  - Return to IDLE.
- ack_error clears when the next tick is accepted.
- Latency: 48 cells (START, Sr, STOP, 45 byte/ack bits) × 4×QTR clocks, plus 1 cycle, from tick to data_valid.
- Open-drain only: the block never drives a line high. Any SCL stretching by the slave is ignored.

Test Plan:
- Sim config: CLK_HZ=4_000_000, I2C_HZ=100_000 (QTR=10), with an I2C slave model at address 0x28.
- Case 1: tick with adress=0001; slave returns 0x0A, 0xBC.
  - Bytes captured in order: 0x50, 0x10, 0x51; master ACK after the MSB, NACK after the LSB.
  - data=0xABC, chan_id=0, ack_error=0.
  - data_valid is a single cycle exactly 1921 clocks after tick.
- Case 2: adress=1000; slave returns 0x3F, 0xFF.
  - Config byte 0x80, data=0xFFF, chan_id=3.
  - Measured SCL period is 40 clocks.
  - No SDA transition while SCL is high, except at START/Sr/STOP.
- Case 3: slave NACKs address 0x50 after a prior good result of 0xABC.
  - ack_error=1, STOP generated, no data_valid, data stays 0xABC.
  - The next good transaction clears ack_error.
- Case 4: second tick 100 clocks after the first.
  - Ignored: exactly one START/STOP pair and one data_valid.
- Case 5: rst asserted for 1 cycle during RD_MSB.
  - Next cycle: scl_oe=0, sda_oe=0, busy=0, data=0.
  - A following tick completes normally with correct data.
